// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: decoded fields in, DATA_W-wide immediates out of a DEPTH-entry FIFO.
// Optional macro IMM_SCALE_EN: scale B/CB immediates to byte offsets.
module imm_extend_pipe #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       instr,
  input  logic [2:0]        ctrl,
  input  logic [1:0]        shft_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ex_num,
  output logic              ex_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] mem_num [DEPTH];
  logic              mem_err [DEPTH];

  logic [63:0]       acc_wide;
  logic [63:0]       movz_wide;
  logic [63:0]       movk_wide;
  logic [63:0]       res_wide;
  logic [DATA_W-1:0] res_num;
  logic              res_err;
  logic              is_move;
  logic              push;
  logic              pop;

  assign acc_wide  = 64'(acc_reg);
  assign movz_wide = 64'(instr[20:5]) << {shft_amt, 4'b0000};
  assign is_move   = (ctrl[2:1] == 2'b10);

  // MOVK: swap in the selected halfword, keep the rest of the accumulator
  for (genvar gi = 0; gi < 4; gi++) begin : g_movk_hw
    assign movk_wide[gi*16 +: 16] = (shft_amt == 2'(gi)) ? instr[20:5] : acc_wide[gi*16 +: 16];
  end

  always_comb begin
    res_wide = '0;
    res_err  = 1'b0;
    case (ctrl)
      3'b000: res_wide = {52'b0, instr[21:10]};
      3'b001: res_wide = {{55{instr[20]}}, instr[20:12]};
`ifdef IMM_SCALE_EN
      3'b010: res_wide = {{36{instr[25]}}, instr[25:0], 2'b00};
      3'b011: res_wide = {{43{instr[23]}}, instr[23:5], 2'b00};
`else
      3'b010: res_wide = {{38{instr[25]}}, instr[25:0]};
      3'b011: res_wide = {{45{instr[23]}}, instr[23:5]};
`endif
      3'b100: res_wide = movz_wide;
      3'b101: res_wide = movk_wide;
      default: res_err = 1'b1;
    endcase
    // upper halfwords do not exist in a 32-bit result
    if ((DATA_W == 32) && is_move && shft_amt[1]) begin
      res_err = 1'b1;
    end
    if (res_err) begin
      res_wide = '0;
    end
  end

  assign res_num   = res_wide[DATA_W-1:0];
  assign out_valid = (count_reg != '0);
  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ex_num    = out_valid ? mem_num[rd_ptr_reg] : '0;
  assign ex_err    = out_valid ? mem_err[rd_ptr_reg] : 1'b0;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      acc_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (is_move && !res_err) begin
          acc_reg <= res_num;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; outputs are gated by out_valid instead
  always_ff @(posedge CLK) begin
    if (push && !Reset) begin
      mem_num[wr_ptr_reg] <= res_num;
      mem_err[wr_ptr_reg] <= res_err;
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined successor to the combinational immediate extender. It accepts decoded instruction fields under a valid/ready handshake and produces a DATA_W-wide extended immediate from a DEPTH-entry output FIFO. It adds MOVK merge support through an internal move accumulator, plus illegal-mode flagging. It sits between decode and the execute-stage operand mux of the pipelined datapath.

## Interface
- DATA_W, 64: result width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; power of two, at least 2.
- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream fields valid.
- in_ready  out  1  block can accept this cycle.
- instr  in  26  instruction bits [25:0].
- ctrl  in  3  extension mode.
- shft_amt  in  2  MOV halfword select (hw field).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- ex_num  out  DATA_W  extended immediate at FIFO head.
- ex_err  out  1  head entry came from an illegal request.

## Operation
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- On accept, compute a result from the ctrl mode and write it with its err bit to the FIFO tail.
- Mode encodings and results (all truncated to DATA_W):
  - 000 I: zero-extend instr[21:10].
  - 001 D: sign-extend instr[20:12].
  - 010 B: sign-extend instr[25:0].
  - 011 CB: sign-extend instr[23:5].
  - 100 MOVZ: instr[20:5] << (16*shft_amt), zeros elsewhere. Also writes the result into the accumulator acc.
  - 101 MOVK: acc with halfword shft_amt replaced by instr[20:5]. Also writes the result into acc.
  - 110/111: illegal. Result 0, err=1, acc unchanged.
- DATA_W=32 with MOVZ/MOVK and shft_amt[1]=1 is illegal: result 0, err=1, acc unchanged.
- Only accepted MOVZ/MOVK requests modify acc. A MOVK immediately after a MOVZ sees the MOVZ value; there is no hazard bubble.
- FIFO:
  - in_ready = (count < DEPTH), a registered count with no combinational path from out_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - ex_num and ex_err are driven from the head entry. When the FIFO is empty they read 0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible with out_valid=1 after edge N.
- Throughput is 1 per cycle while out_ready=1.
- When full, in_ready=0. A pop in that cycle raises in_ready on the next cycle, not the same one.
- ex_num and ex_err hold stable while out_valid && !out_ready.
- Reset (synchronous, active-high), values after the edge:
  - count=0, pointers=0, acc=0.
  - out_valid=0, in_ready=1, ex_num=0, ex_err=0.
- Reset asserted mid-stream flushes all entries. An accept attempted in the same cycle as Reset is dropped.
- Upstream must hold instr/ctrl/shft_amt stable while in_valid && !in_ready.

## Configuration
- IMM_SCALE_EN defined: B and CB results are scaled to byte offsets.
  - B = sign-extend {instr[25:0], 2'b00}.
  - CB = sign-extend {instr[23:5], 2'b00}.
- IMM_SCALE_EN undefined: B and CB are unscaled word offsets, as listed above.
- All other modes are identical in both builds.

## Test plan
- Reset, then push I with instr[21:10]=12'hFFF -> after 1 cycle, out_valid=1, ex_num=64'h0000_0000_0000_0FFF, ex_err=0.
- Push D with instr[20:12]=9'h100 -> ex_num=64'hFFFF_FFFF_FFFF_FF00. Push B with instr=26'h3FFFFFF -> ex_num=-1 (unscaled) or -4 (IMM_SCALE_EN).
- Push MOVZ (imm=16'h1234, shft_amt=0), then MOVK (imm=16'hABCD, shft_amt=3) on back-to-back cycles -> two entries: 64'h1234, then 64'hABCD_0000_0000_1234.
- Hold out_ready=0 and push DEPTH entries -> in_ready=0 and the head stays stable. Raise out_ready for one cycle -> one pop, and in_ready=1 on the following cycle.
- Push ctrl=3'b111 -> ex_num=0, ex_err=1. A subsequent MOVK (shft_amt=0, imm=16'h5555) merges into the unchanged acc.
- With the FIFO holding 2 entries, assert Reset for 1 cycle -> out_valid=0, ex_num=0. A MOVK afterward yields only the inserted halfword, confirming acc=0.
